bster_tree_ram: RTL
===================

# bster_tree_ram

AXI4 memory responder holding the BSTer binary tree: the slave end of the core's `ram_axi_*` initiator port. It stores `2**DEPTH_LOG2` words in an internal array and serves one write burst and one read burst at a time, through independent write and read state machines. It accepts the core's INCR/FIXED single-ID traffic and signals protocol misuse with SLVERR instead of hanging.

## Interface
- `DATA_WIDTH`, default 32: data bus width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, default 16: byte address width.
- `STRB_WIDTH`, default `DATA_WIDTH/8`: write strobe width.
- `ID_WIDTH`, default 8: transaction ID width.
- `DEPTH_LOG2`, default 10: log2 of the number of stored words.
- `aclk` in, 1: clock. All logic is rising-edge.
- `areset` in, 1: reset, asynchronous, active-high.
- `awid` in `ID_WIDTH`, `awaddr` in `ADDR_WIDTH`, `awlen` in 8, `awsize` in 3, `awburst` in 2: write address channel.
- `awlock` in 1, `awcache` in 4, `awprot` in 3: accepted and ignored.
- `awvalid` in 1, `awready` out 1: write address handshake.
- `wdata` in `DATA_WIDTH`, `wstrb` in `STRB_WIDTH`, `wlast` in 1, `wvalid` in 1, `wready` out 1: write data channel.
- `bid` out `ID_WIDTH`, `bresp` out 2, `bvalid` out 1, `bready` in 1: write response channel.
- `arid` in `ID_WIDTH`, `araddr` in `ADDR_WIDTH`, `arlen` in 8, `arsize` in 3, `arburst` in 2: read address channel.
- `arlock` in 1, `arcache` in 4, `arprot` in 3: accepted and ignored.
- `arvalid` in 1, `arready` out 1: read address handshake.
- `rid` out `ID_WIDTH`, `rdata` out `DATA_WIDTH`, `rresp` out 2, `rlast` out 1, `rvalid` out 1, `rready` in 1: read data channel.

## Operation
- **Addressing.** Word index = `addr[DEPTH_LOG2+log2(STRB_WIDTH)-1 : log2(STRB_WIDTH)]`. Upper address bits are ignored, so addresses alias. The memory array is not reset.
- **Burst address update**, per beat, on an 8-bit-length, `ADDR_WIDTH`-bit counter:
  - FIXED (00): address constant.
  - INCR (01): `addr += 2**size`, wrapping modulo `2**ADDR_WIDTH`.
  - WRAP (10) and reserved (11): handled as INCR; the response is SLVERR.
- **Illegal size.** `size > log2(STRB_WIDTH)`: response is SLVERR, and write beats do not modify memory.
- **Write FSM.** States W_IDLE, W_DATA, W_RESP.
  - W_IDLE: `awready`=1. On the AW handshake, latch id/addr/len/size/burst, clear the beat counter, go to W_DATA.
  - W_DATA: `wready`=1. Each W handshake writes the bytes whose `wstrb` bit is set, then advances the address and the beat counter.
  - Beats after beat `awlen` are consumed but not written.
  - The W handshake with `wlast`=1 moves the FSM to W_RESP. If the beat count at that point is not `awlen+1`, `bresp`=SLVERR (10).
  - W_RESP: `bvalid`=1, `bid`=latched id, `bresp`=OKAY (00) unless an error was flagged. The B handshake returns the FSM to W_IDLE.
- **Read FSM.** States R_IDLE, R_DATA.
  - R_IDLE: `arready`=1. The AR handshake latches the command and loads `rdata` with word[addr], then goes to R_DATA.
  - R_DATA: `rvalid`=1, `rid`=latched id, `rresp` = OKAY or SLVERR.
  - `rlast`=1 when beat count equals `arlen`.
  - Each R handshake on a non-last beat loads the next beat's word on the same edge.
  - The R handshake with `rlast` returns the FSM to R_IDLE, with `rvalid`=0 and `rlast`=0.
- **SLVERR on reads.** `rdata` still carries memory contents.
- **Independence.** The read and write FSMs run concurrently. There is no AW/W reordering: W beats are refused (`wready`=0) until the AW handshake has happened.

## Timing
- **Reset values** while `areset`=1, and in the cycle it deasserts:
  - `awready`, `wready`, `bvalid`, `arready`, `rvalid`, `rlast`: 0.
  - `bid`, `bresp`, `rid`, `rdata`, `rresp`: 0.
- After reset: `awready`=1 and `arready`=1 from the first rising edge after `areset` falls.
- Write path:
  - AW handshake at edge N: `wready`=1 after edge N.
  - Last W beat at edge M: `bvalid`=1 after M. `bvalid` holds, with stable `bid`/`bresp`, until `bready`.
  - `awready` rises after the B-handshake edge.
  - Minimum single-beat write is 3 cycles from AW to B handshake.
- Read path:
  - AR-to-first-`rvalid` latency is 1 cycle.
  - Throughput is 1 beat per cycle while `rready`=1.
  - Stalled beats hold `rdata`, `rlast`, `rresp`, `rid` stable.
  - After the last beat, `arready` rises on the following cycle.
- Same-word read load and write on the same edge: the read returns the old data.
- Reset asserted mid-burst: both FSMs go idle immediately. Any in-flight response is dropped, and memory keeps the beats already written.

## Test plan
- **Reset.** Hold `areset`=1 → all ready/valid outputs 0. Release → `awready`=`arready`=1 one edge later, `bresp`=`rresp`=0.
- **INCR round trip.** INCR write of 4 beats at 0x0010, data 0xA0..0xA3, strobe 0xF, `awid`=5 → `bvalid` with `bid`=5 and `bresp`=00. INCR read of 4 beats at 0x0010 with `arid`=7 → `rdata` A0,A1,A2,A3, `rlast` on beat 3 only, `rid`=7.
- **Partial strobe.** Write 0xFFFFFFFF to 0x0040, then 0x12345678 with `wstrb`=0x3 → read returns 0xFFFF5678.
- **Stall with FIXED.** Read of 3 beats, FIXED, at 0x0010, with `rready` toggled 1/0 each cycle → three beats of 0xA0, outputs stable during stalls, `arready` back one cycle after the last handshake.
- **Protocol errors.**
  - `awlen`=3 with `wlast` on beat 1 → `bresp`=10.
  - `awsize`=3 with 32-bit data → `bresp`=10, memory unchanged.
  - `arburst`=10 → `rresp`=10 on all beats.
- **Concurrency and reset.**
  - Overlapping 8-beat write and 8-beat read to disjoint words → both complete correctly.
  - `areset` asserted during beat 2 of a write → `wready`=0 immediately; the first two beats are present on readback.

Source files
------------

// File: rtl/bster_tree_ram.sv
// AXI4 memory responder holding the BSTer tree words: one write burst and one read burst
// in flight at a time, each owned by its own state machine; misuse answers SLVERR.
module bster_tree_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  awlock,
    input  logic [3:0]            awcache,
    input  logic [2:0]            awprot,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [ID_WIDTH-1:0]   bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arlock,
    input  logic [3:0]            arcache,
    input  logic [2:0]            arprot,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);
    localparam int SIZE_LOG2 = $clog2(STRB_WIDTH);
    localparam int DEPTH     = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [2:0] s, input logic [1:0] b);
        next_addr = (b == 2'b00) ? a : a + (ADDR_WIDTH'(1) << s);
    endfunction

    function automatic logic size_bad(input logic [2:0] s);
        size_bad = ({29'd0, s} > 32'(SIZE_LOG2));
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    w_state_t              r_wstate;
    logic                  r_awready, r_wready, r_bvalid;
    logic [ID_WIDTH-1:0]   r_bid;
    logic [1:0]            r_bresp;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [7:0]            r_wlen;
    logic [2:0]            r_wsize;
    logic [1:0]            r_wburst;
    logic [8:0]            r_wbeat;
    logic                  r_wsize_bad, r_werr;

    r_state_t              r_rstate;
    logic                  r_arready, r_rvalid, r_rlast;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [7:0]            r_rlen, r_rbeat;
    logic [2:0]            r_rsize;
    logic [1:0]            r_rburst;

    logic [DEPTH_LOG2-1:0] w_widx, w_ar_idx, w_r_idx;
    logic                  w_wr_en;
    logic                  w_unused_sideband;

    assign w_widx   = r_waddr[DEPTH_LOG2+SIZE_LOG2-1:SIZE_LOG2];
    assign w_ar_idx = araddr[DEPTH_LOG2+SIZE_LOG2-1:SIZE_LOG2];
    assign w_r_idx  = r_raddr[DEPTH_LOG2+SIZE_LOG2-1:SIZE_LOG2];
    // Beats past awlen and bursts with an illegal size are consumed without touching memory.
    assign w_wr_en  = r_wready && wvalid && !r_wsize_bad && (r_wbeat <= {1'b0, r_wlen});
    assign w_unused_sideband = ^{awlock, awcache, awprot, arlock, arcache, arprot};

    always_ff @(posedge aclk) begin
        if (w_wr_en) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wstrb[b]) r_mem[w_widx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wstate    <= W_IDLE;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bid       <= '0;
            r_bresp     <= 2'b00;
            r_waddr     <= '0;
            r_wlen      <= '0;
            r_wsize     <= '0;
            r_wburst    <= '0;
            r_wbeat     <= '0;
            r_wsize_bad <= 1'b0;
            r_werr      <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (awvalid && r_awready) begin
                        r_awready   <= 1'b0;
                        r_wready    <= 1'b1;
                        r_bid       <= awid;
                        r_waddr     <= awaddr;
                        r_wlen      <= awlen;
                        r_wsize     <= awsize;
                        r_wburst    <= awburst;
                        r_wbeat     <= '0;
                        r_wsize_bad <= size_bad(awsize);
                        r_werr      <= awburst[1] | size_bad(awsize);
                        r_wstate    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid && r_wready) begin
                        r_waddr <= next_addr(r_waddr, r_wsize, r_wburst);
                        if (r_wbeat != '1) r_wbeat <= r_wbeat + 9'd1;
                        if (wlast) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr || r_wbeat != {1'b0, r_wlen}) ? 2'b10 : 2'b00;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready && r_bvalid) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
            r_raddr   <= '0;
            r_rlen    <= '0;
            r_rbeat   <= '0;
            r_rsize   <= '0;
            r_rburst  <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (arvalid && r_arready) begin
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rid     <= arid;
                        r_rdata   <= r_mem[w_ar_idx];
                        r_rresp   <= (arburst[1] | size_bad(arsize)) ? 2'b10 : 2'b00;
                        r_rlast   <= (arlen == 8'd0);
                        r_rbeat   <= '0;
                        r_rlen    <= arlen;
                        r_rsize   <= arsize;
                        r_rburst  <= arburst;
                        r_raddr   <= next_addr(araddr, arsize, arburst);
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    // r_raddr already points at the next beat, so its word loads on this handshake.
                    if (rready && r_rvalid) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_rdata <= r_mem[w_r_idx];
                            r_raddr <= next_addr(r_raddr, r_rsize, r_rburst);
                            r_rbeat <= r_rbeat + 8'd1;
                            r_rlast <= ((r_rbeat + 8'd1) == r_rlen);
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bid     = r_bid;
    assign bresp   = r_bresp;
    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rlast   = r_rlast;
    assign rid     = r_rid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
endmodule
